// File: rtl/gates_pkg.sv
// Shared constants, state encoding and sizing helper for the popcount gate blocks.
// Latency: n/a (compile-time items only).
// Backpressure: n/a.
package gates_pkg;

   // Operand comparison mode, latched once per frame.
   localparam logic MODE_XNOR = 1'b0;   // count matching bit positions
   localparam logic MODE_XOR  = 1'b1;   // count differing bit positions (Hamming distance)

   typedef enum logic {
      ST_ACC  = 1'b0,   // taking operand beats
      ST_HOLD = 1'b1    // presenting a finished frame result
   } state_t;

   // Smallest r with 2**r >= n; used to size counters and result buses.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of one operand word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result follows the input in the same cycle.
// Ports: data - word to count; ones - number of set bits in data.
module popcount
   import gates_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int OW    = clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   output logic [OW-1:0]    ones
);

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + OW'(data[i]);
      end
   end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Accumulates per-beat XNOR match counts or XOR Hamming distances over a frame of BEATS beats.
// Latency: result valid 1 cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result is held; the result stays until out_ready takes it.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/a/b/mode/abort operand side;
//        out_valid/out_ready/count/out_mode result side.
module xnor_popcount_acc
   import gates_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int BEATS = 4,
   localparam int CW    = clog2(WIDTH * BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             out_mode
);

   localparam int PW = clog2(WIDTH + 1);
   // Beat index needs at least one bit even when BEATS == 1.
   localparam int BW = (BEATS > 1) ? clog2(BEATS) : 1;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_idx;
   logic [CW-1:0]   acc;
   logic            frame_mode;

   logic            first_beat;
   logic            last_beat;
   logic            eff_mode;
   logic [WIDTH-1:0] beat_vec;
   logic [PW-1:0]   term;
   logic [CW-1:0]   sum;

   assign first_beat = (beat_idx == '0);
   assign last_beat  = (beat_idx == BW'(BEATS - 1));

   // The first beat of a frame uses the live mode input; later beats use the
   // latched copy so mid-frame mode toggles cannot split a frame's semantics.
   assign eff_mode = first_beat ? mode : frame_mode;
   assign beat_vec = (eff_mode == MODE_XOR) ? (a ^ b) : ~(a ^ b);

   popcount #(.WIDTH(WIDTH)) u_popcount (
      .data (beat_vec),
      .ones (term)
   );

   // First beat restarts the sum rather than adding to stale acc contents.
   assign sum = first_beat ? CW'(term) : acc + CW'(term);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_ACC;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_ACC: begin
            in_ready = 1'b1;
            // abort beats any beat offered in the same cycle, final beat included
            if (in_valid && !abort && last_beat) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_ACC;
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         beat_idx   <= '0;
         frame_mode <= MODE_XNOR;
         count      <= '0;
         out_mode   <= MODE_XNOR;
      end else if (state_q == ST_ACC) begin
         if (abort) begin
            acc      <= '0;
            beat_idx <= '0;
         end else if (in_valid) begin
            acc <= sum;
            if (first_beat) frame_mode <= mode;
            if (last_beat) begin
               beat_idx <= '0;
               count    <= sum;
               out_mode <= eff_mode;
            end else begin
               beat_idx <= beat_idx + BW'(1);
            end
         end
      end
   end

endmodule

// File: doc/xnor_popcount_acc.md
XNOR_POPCOUNT_ACC -- requirements
Module: xnor_popcount_acc

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each operand beat; legal range 1 to 64.
REQ-002 Parameter BEATS, default 4, number of operand beats per frame; legal range 1 to 256.
REQ-003 Derived constant CW = clog2(WIDTH*BEATS+1), the result width; 6 for the default parameters.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  an operand beat is present on a and b.
REQ-007 in_ready  output  1  the block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A beat.
REQ-009 b  input  WIDTH  operand B beat.
REQ-010 mode  input  1  0 = XNOR match count, 1 = XOR Hamming distance; sampled on the first beat of a frame.
REQ-011 abort  input  1  discards the partial frame.
REQ-012 out_valid  output  1  the frame result is valid.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 count  output  CW  the frame result.
REQ-015 out_mode  output  1  the mode the presented result was computed with.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1 in the same cycle; a result is taken when out_valid and out_ready are both 1.
REQ-017 The block has two states:
- ACC: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-018 The per-beat term is the popcount of ~(a^b) in mode 0, and the popcount of (a^b) in mode 1.
REQ-019 On the first accepted beat of a frame (beat index 0):
- acc loads that beat's term;
- the frame mode is latched from mode.
REQ-020 On later accepted beats, acc adds that beat's term using the latched mode; mode changes mid-frame have no effect.
REQ-021 The beat index increments on each accepted beat and wraps to 0 after BEATS-1; with BEATS=1 every beat is both first and last.
REQ-022 Accepting beat BEATS-1 moves ACC to HOLD on the next edge.
- Latency is 1 cycle: out_valid=1 in the cycle after the last beat is accepted.
- count then holds the full frame sum; out_mode holds the latched frame mode.
REQ-023 In HOLD, count and out_mode stay stable until the result is taken; the result is taken and the block returns to ACC on the same edge.
- No beat is accepted in the HOLD cycle where the result is taken.
REQ-024 count never overflows, since the maximum is WIDTH*BEATS. Accumulation is unsigned, and each term is zero-extended to CW bits.
REQ-025 abort=1 in ACC clears acc and the beat index to 0, and any beat presented in that same cycle is discarded, including the final beat (abort wins).
REQ-026 abort=1 in HOLD is ignored; the pending result is still delivered.
REQ-027 in_valid=0 cycles inside a frame stall it indefinitely without changing acc or the beat index.

Reset
REQ-028 When rst=1 at a clock edge the block enters ACC, with:
- acc = 0, beat index = 0;
- count = 0, out_mode = 0;
- out_valid = 0, in_ready = 1 from the cycle after reset.
REQ-029 Reset mid-frame or in HOLD discards all partial or pending data, and rst has priority over abort and over both handshakes.

Structure
REQ-030 The shared package gates_pkg holds:
- the clog2 constant function;
- the mode encodings MODE_XNOR=1'b0 and MODE_XOR=1'b1.
REQ-031 A combinational sub-module popcount (parameter WIDTH, output width clog2(WIDTH+1)) computes the per-beat term; the FSM, counter and accumulator live in the top level.

Verification (WIDTH=8, BEATS=4)
REQ-032 mode 0, a=b=8'hFF for 4 back-to-back beats -> out_valid one cycle after beat 4, count=32, out_mode=0.
REQ-033 Cases with 4 beats each:
- mode 0, a=8'hAA, b=8'hA5 -> count=16;
- mode 1, same data -> count=16, out_mode=1;
- mode 1, a=8'h0F, b=8'hF0 -> count=32.
REQ-034 Back-pressure: hold out_ready=0 for 5 cycles after a result appears -> count stable and in_ready=0 for those 5 cycles, with beats offered on in_valid not consumed; raise out_ready -> ACC on the next edge.
REQ-035 abort after 2 beats of a=8'h00, b=8'hFF in mode 0, then a full frame with a=b=8'h00 in mode 0 -> single result count=32.
REQ-036 rst after 3 beats, then a new frame with a=8'h01, b=8'h00 in mode 1 -> count=4, and no result from the interrupted frame.
REQ-037 Flip mode on beats 2 to 4 of a frame -> the result uses the beat-1 mode, with out_mode matching it.
